register_file: RTL
==================

# register_file

Parametrised multi-entry register file for the five-stage pipeline, replacing the single edge-triggered register. Two registered read ports and one write port are synchronous to one clock. A per-entry pending-write scoreboard raises a read hazard so decode can stall. Outputs drive defined values at all times; there is no high-Z read bus.

## Interface
- N, 16, data width in bits
- DEPTH, 8, number of registers
- ADDR_W, 3, address width; must satisfy 2^ADDR_W >= DEPTH
- clk  input  1  clock; all state changes on rising edge
- reset  input  1  synchronous, active-high reset
- rd_en  input  1  read request for both ports this cycle
- rd_addr_a  input  ADDR_W  port A source address
- rd_addr_b  input  ADDR_W  port B source address
- rd_data_a  output  N  port A data, registered
- rd_data_b  output  N  port B data, registered
- rd_valid  output  1  rd_data_a/b hold a fresh read this cycle
- hazard  output  1  combinational; the current read request sources a pending register
- wr_en  input  1  writeback strobe
- wr_addr  input  ADDR_W  writeback destination
- wr_data  input  N  writeback data
- issue_en  input  1  an instruction targeting issue_addr has been issued
- issue_addr  input  ADDR_W  destination to mark pending
- pending  output  DEPTH  scoreboard bits, registered

## Operation
- Reset (reset=1 at an edge):
  - all registers, rd_data_a/b and pending clear to 0
  - rd_valid = 0
  - reset overrides every concurrent request; in-flight reads are dropped
- Read:
  - hazard = rd_en & (pending[rd_addr_a] | pending[rd_addr_b]), after the bypass masking below
  - rd_en=1 with hazard=0 at edge T: at T+1, rd_data_a = reg[rd_addr_a], rd_data_b = reg[rd_addr_b], rd_valid=1
  - rd_en=1 with hazard=1: read suppressed; rd_valid=0 at T+1; rd_data holds its previous value
  - rd_valid is a one-cycle pulse per accepted read
  - rd_data holds its value when there is no read
- Write:
  - wr_en=1 at edge: reg[wr_addr] <= wr_data and pending[wr_addr] <= 0
- Issue:
  - issue_en=1 at edge: pending[issue_addr] <= 1
  - pending is a single bit; re-issuing to a pending entry leaves it pending
- Simultaneous events:
  - issue and write to the same address: issue wins, pending stays 1
  - write and read of the same address: old value returned unless bypass is compiled in
- Out-of-range address (>= DEPTH): write and issue are ignored; a read returns 0 and never raises hazard.

## Timing
- Read latency: 1 cycle, request edge to rd_valid.
- Back-to-back reads are accepted every cycle.
- Write-to-visible latency: 1 cycle, or 0 with bypass.
- hazard is combinational from rd_en, rd_addr_a/b, pending, and (with bypass) wr_en/wr_addr.
- No combinational path from wr_data to any output without bypass.

## Configuration
- REGFILE_BYPASS_EN defined:
  - on a same-cycle wr_en to a read address, that port captures wr_data
  - that source's pending bit is masked out of hazard
- REGFILE_BYPASS_EN undefined:
  - reads return the pre-write register contents
  - hazard uses raw pending bits

## Structure
- Shared package regfile_pkg holds:
  - defaults REGFILE_N=16, REGFILE_DEPTH=8, REGFILE_ADDR_W=3
  - a function for the address-in-range check
- Sub-module regfile_scoreboard: DEPTH-bit pending vector with the issue/clear priority and hazard lookup.
- Storage array and read registers live in register_file.

## Test plan
- Reset mid-read: rd_en=1 at T, reset=1 at T+1 -> rd_valid=0 and rd_data_a=0 at T+2, all registers read 0 afterwards.
- Write reg[3]=16'hBEEF, then read A=3, B=0 next cycle -> one cycle later rd_data_a=16'hBEEF, rd_data_b=0, rd_valid=1 for exactly one cycle.
- Issue addr 5, then rd_en with A=5 -> hazard=1 and no rd_valid; wr_en to 5 with 16'h1234 -> pending[5]=0, retried read returns 16'h1234.
- Same edge: issue_en and wr_en to addr 2 -> pending[2]=1 and reg[2] updated.
- Same cycle: wr 16'h00AA and read to addr 7 (old value 16'h0055) -> rd_data_a=16'h0055 without the macro, 16'h00AA with REGFILE_BYPASS_EN.
- DEPTH=6, write addr 7 with 16'hFFFF -> no register changes; a read of addr 7 returns 0 with hazard=0.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and helpers for the pipeline register file.
//   REGFILE_N / REGFILE_DEPTH / REGFILE_ADDR_W : default data width, entry
//   count and address width.
//   addr_in_range() : true when an address selects an implemented entry.
package regfile_pkg;

  localparam int REGFILE_N      = 16;
  localparam int REGFILE_DEPTH  = 8;
  localparam int REGFILE_ADDR_W = 3;

  function automatic logic addr_in_range(input int unsigned addr, input int unsigned depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/register_file_if.sv
// register_file_if: read, writeback and issue signals of the register file.
//   master : decode/writeback side (drives requests, receives data/status)
//   slave  : register file side
// Read handshake: a read is taken on any rising edge where rd_en=1 and
// hazard=0; its data appears with a one-cycle rd_valid pulse after that edge.
// With hazard=1 the request is simply not taken and must be held or retried.
interface register_file_if #(
  parameter int N      = 16,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) ();

  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [N-1:0]      rd_data_a;
  logic [N-1:0]      rd_data_b;
  logic              rd_valid;
  logic              hazard;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [N-1:0]      wr_data;
  logic              issue_en;
  logic [ADDR_W-1:0] issue_addr;
  logic [DEPTH-1:0]  pending;

  modport master (
    output rd_en, rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, issue_en, issue_addr,
    input  rd_data_a, rd_data_b, rd_valid, hazard, pending
  );

  modport slave (
    input  rd_en, rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, issue_en, issue_addr,
    output rd_data_a, rd_data_b, rd_valid, hazard, pending
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-entry pending-write bits and read hazard lookup.
//   clk, reset              : clock, synchronous active-high reset
//   issue_en, issue_addr    : mark a destination pending
//   wr_en, wr_addr          : writeback clears the destination's pending bit
//   rd_en, rd_addr_a/b      : current read request
//   pending                 : registered scoreboard bits
//   hazard                  : combinational, read sources a pending entry
// Optional build macro: REGFILE_BYPASS_EN masks a source whose writeback
// lands in the same cycle, since the read port captures that data directly.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH  = REGFILE_DEPTH,
  parameter int ADDR_W = REGFILE_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_addr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DEPTH-1:0]  pending,
  output logic              hazard
);

  logic [DEPTH-1:0] pending_q;
  logic [DEPTH-1:0] pending_d;
  logic             src_hit_a;
  logic             src_hit_b;

  // Addresses at or above DEPTH never match an index, so out-of-range issue
  // and write requests fall through untouched and never report pending.
  function automatic logic src_pending(input logic [DEPTH-1:0] bits,
                                       input logic [ADDR_W-1:0] addr);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (addr == ADDR_W'(i)) hit = bits[i];
    end
    return hit;
  endfunction

  // Issue beats writeback: the newer instruction still owns the entry.
  always_comb begin
    pending_d = pending_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (issue_en && issue_addr == ADDR_W'(i)) begin
        pending_d[i] = 1'b1;
      end else if (wr_en && wr_addr == ADDR_W'(i)) begin
        pending_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) pending_q <= '0;
    else       pending_q <= pending_d;
  end

  always_comb begin
    src_hit_a = src_pending(pending_q, rd_addr_a);
    src_hit_b = src_pending(pending_q, rd_addr_b);
`ifdef REGFILE_BYPASS_EN
    if (wr_en && wr_addr == rd_addr_a) src_hit_a = 1'b0;
    if (wr_en && wr_addr == rd_addr_b) src_hit_b = 1'b0;
`endif
  end

  assign hazard  = rd_en & (src_hit_a | src_hit_b);
  assign pending = pending_q;

endmodule

// File: rtl/register_file.sv
// register_file: multi-entry register file with two registered read ports,
// one write port and a pending-write scoreboard for decode stalls.
//   clk, reset : clock, synchronous active-high reset
//   bus        : register_file_if slave (read request/data, rd_valid, hazard,
//                writeback, issue, pending)
// Optional build macro: REGFILE_BYPASS_EN forwards same-cycle wr_data into a
// read port addressing the written entry. Without it reads see the old value
// and wr_data has no path to any output except through the storage array.
module register_file
  import regfile_pkg::*;
#(
  parameter int N      = REGFILE_N,
  parameter int DEPTH  = REGFILE_DEPTH,
  parameter int ADDR_W = REGFILE_ADDR_W
) (
  input  logic           clk,
  input  logic           reset,
  register_file_if.slave bus
);

  logic [N-1:0] mem_q [DEPTH];
  logic [N-1:0] rd_data_a_q;
  logic [N-1:0] rd_data_b_q;
  logic         rd_valid_q;
  logic [N-1:0] src_a;
  logic [N-1:0] src_b;
  logic         hazard;
  logic         accept;

  // Out-of-range addresses match no entry and read as zero.
  function automatic logic [N-1:0] lookup(input logic [ADDR_W-1:0] addr);
    logic [N-1:0] val;
    val = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (addr == ADDR_W'(i)) val = mem_q[i];
    end
    return val;
  endfunction

  regfile_scoreboard #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .issue_en   (bus.issue_en),
    .issue_addr (bus.issue_addr),
    .wr_en      (bus.wr_en),
    .wr_addr    (bus.wr_addr),
    .rd_en      (bus.rd_en),
    .rd_addr_a  (bus.rd_addr_a),
    .rd_addr_b  (bus.rd_addr_b),
    .pending    (bus.pending),
    .hazard     (hazard)
  );

  always_comb begin
    src_a = lookup(bus.rd_addr_a);
    src_b = lookup(bus.rd_addr_b);
`ifdef REGFILE_BYPASS_EN
    if (bus.wr_en && addr_in_range(32'(bus.wr_addr), DEPTH)) begin
      if (bus.wr_addr == bus.rd_addr_a) src_a = bus.wr_data;
      if (bus.wr_addr == bus.rd_addr_b) src_b = bus.wr_data;
    end
`endif
  end

  assign accept = bus.rd_en & ~hazard;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_data_a_q <= '0;
      rd_data_b_q <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (bus.wr_en && bus.wr_addr == ADDR_W'(i)) mem_q[i] <= bus.wr_data;
      end
      rd_valid_q <= accept;
      if (accept) begin
        rd_data_a_q <= src_a;
        rd_data_b_q <= src_b;
      end
    end
  end

  assign bus.rd_data_a = rd_data_a_q;
  assign bus.rd_data_b = rd_data_b_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.hazard    = hazard;

endmodule
